number_uart_sender: RTL and testbench
=====================================

Name: number_uart_sender

Overview:
- Downstream consumer of the 256-bit random number produced by number_counter.
- On a one-cycle start pulse (a button_handler_down flag), snapshots the whole number and serialises it byte by byte over a UART TX line, 8N1 framing.
- Gives the host PC the full generated value without having to step through all 32 bytes on the LEDs.
- Sits beside show_number in main, fed from the same number bus.

Parameters:
- SIZE, 256, width of the input number; must be a multiple of 8.
- CLK_DIV, 434, clock cycles per UART bit; must be at least 2.
- IDX_W, 6, width of byte_idx; must satisfy 2^IDX_W > SIZE/8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- number  input  SIZE  value to transmit; sampled only on an accepted start.
- start  input  1  one-cycle request pulse.
- tx  output  1  UART line; idles high.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- byte_idx  output  IDX_W  index of the byte currently on the line (0 = number[7:0]).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, done=0, byte_idx=0.
  - FSM in IDLE; bit and baud counters at 0.
  - The shadow register is cleared to 0.
- FSM states: IDLE, START_BIT, DATA, STOP_BIT.
- IDLE:
  - start=1 is sampled at a rising edge. At that edge: shadow <= number, byte_idx <= 0, state <= START_BIT, busy <= 1.
  - tx goes low on the same edge; the cycle after the start pulse is the first start-bit cycle.
- START_BIT: tx=0 for exactly CLK_DIV cycles, then DATA with bit counter 0.
- DATA:
  - tx = shadow[byte_idx*8 + bitcnt], LSB first, each bit held CLK_DIV cycles.
  - After bit 7, go to STOP_BIT.
- STOP_BIT: tx=1 for CLK_DIV cycles. Then:
  - If byte_idx < SIZE/8-1: byte_idx increments and the FSM returns to START_BIT with no idle gap between frames.
  - Otherwise: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle.
- Timing:
  - Frame length is 10*CLK_DIV cycles.
  - Total transfer is (SIZE/8)*10*CLK_DIV cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Baud counter counts 0..CLK_DIV-1 and wraps. All bit boundaries come from its terminal count.
- start while busy=1 is ignored: no restart, no re-snapshot.
- start in the same cycle as done is accepted. The new transfer begins immediately and done still pulses.
- Changes on number during a transfer have no effect; the snapshot alone is sent.
- byte_idx holds its final value (SIZE/8-1) after completion until the next accepted start or a reset.

Optional Feature:
- Macro: NUMBER_UART_CHECKSUM_EN.
- When defined:
  - After the last data byte, one extra 8N1 frame carries the XOR of all SIZE/8 snapshot bytes.
  - During that frame byte_idx = SIZE/8.
  - done pulses after its stop bit.
  - Total transfer becomes (SIZE/8+1)*10*CLK_DIV cycles.
- When undefined: no checksum frame and no checksum logic.

Test Plan:
All scenarios use CLK_DIV=4, SIZE=256.
- Reset, then idle 50 cycles -> tx=1, busy=0, done=0, byte_idx=0 throughout.
- number=256'h...0201 (byte k = k+1), one start pulse:
  - busy rises the next cycle and 32 frames are decoded.
  - Bytes arrive as 0x01, 0x02 … 0x20.
  - busy lasts exactly 1280 cycles, then a single-cycle done.
- Start pulse, then change number and pulse start again at cycle 100 -> decoded bytes match the first snapshot; the transfer still ends at 1280 cycles with one done.
- Assert reset at cycle 57 of a transfer -> tx=1, busy=0 immediately (before the next clock edge). A subsequent start sends a full fresh transfer.
- start coincident with done -> the second transfer's start bit begins the next cycle with no idle gap; both done pulses are observed.
- With NUMBER_UART_CHECKSUM_EN and number = all-0xA5 bytes:
  - 33 frames are sent; the last is 0x00.
  - Changing byte 0 to 0x5A makes the last frame 0xFF.
  - Transfer length is 1320 cycles.

Source files
------------

// File: rtl/number_uart_sender.sv
// Serialises a snapshot of a SIZE-bit number over an 8N1 UART line, byte 0 first.
// Optional trailing XOR checksum frame: define NUMBER_UART_CHECKSUM_EN.
module number_uart_sender #(
    parameter int unsigned SIZE    = 256,
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned IDX_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SIZE-1:0]  number,
    input  logic             start,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] byte_idx
);

    localparam int unsigned NBYTES = SIZE / 8;
    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef NUMBER_UART_CHECKSUM_EN
    localparam int unsigned LAST_IDX = NBYTES;
`else
    localparam int unsigned LAST_IDX = NBYTES - 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SIZE-1:0]   shadow_q, shadow_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        byte_sel;
    logic              baud_term;

    assign baud_term = (baud_q == BAUD_W'(CLK_DIV - 1));

    // Byte currently being framed (checksum byte when past the last data byte)
`ifdef NUMBER_UART_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        byte_sel = '0;
        csum     = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            csum = csum ^ shadow_q[i*8 +: 8];
            if (idx_q == IDX_W'(i)) byte_sel = shadow_q[i*8 +: 8];
        end
        if (idx_q == IDX_W'(NBYTES)) byte_sel = csum;
    end
`else
    always_comb begin
        byte_sel = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) byte_sel = shadow_q[i*8 +: 8];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // tx is computed one edge ahead so the line changes exactly on bit boundaries
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_term ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = number;
                    idx_d    = '0;
                    bit_d    = '0;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START_BIT;
                end
            end
            START_BIT: begin
                if (baud_term) begin
                    bit_d   = '0;
                    tx_d    = byte_sel[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_term) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_sel[bit_q + 3'd1];
                    end
                end
            end
            STOP_BIT: begin
                if (baud_term) begin
                    if (idx_q < IDX_W'(LAST_IDX)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = 1'b0;
                        state_d = START_BIT;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_idx = idx_q;

endmodule

// File: tb/tb_number_uart_sender.sv
// Directed bench for number_uart_sender at CLK_DIV=4, SIZE=256; decodes each 8N1 frame.
// Covers the checksum frame when NUMBER_UART_CHECKSUM_EN is defined.
module tb_number_uart_sender;

    localparam int unsigned SIZE    = 256;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned NBYTES  = SIZE / 8;
    localparam int          FRAME   = 10 * CLK_DIV;
`ifdef NUMBER_UART_CHECKSUM_EN
    localparam int          NFR     = NBYTES + 1;
`else
    localparam int          NFR     = NBYTES;
`endif

    logic             clk;
    logic             reset;
    logic [SIZE-1:0]  number;
    logic             start;
    logic             tx;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] byte_idx;

    int vecs = 0;
    int errs = 0;

    number_uart_sender #(
        .SIZE    (SIZE),
        .CLK_DIV (CLK_DIV),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .number   (number),
        .start    (start),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .byte_idx (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] pat(input int mul, input int add);
        logic [SIZE-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NBYTES); k++) v[k*8 +: 8] = 8'(k * mul + add);
        return v;
    endfunction

    // Pulses start with num at the current negedge, then checks every frame and the done cycle.
    // Returns at the negedge of the done cycle so the caller may issue a coincident start.
    task automatic xfer(input string name, input logic [SIZE-1:0] num, input int chg_at,
                        input logic [SIZE-1:0] chg_num);
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       sbit;
        logic       pbit;
        int         bad_busy;
        int         bad_done;
        bad_busy = 0;
        bad_done = 0;
        rx       = '0;
        sbit     = 1'b1;
        number   = num;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < NFR * FRAME; c++) begin
            int f;
            int b;
            f = c / FRAME;
            b = (c % FRAME) / CLK_DIV;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
            if ((c % CLK_DIV) == CLK_DIV / 2) begin
                if (b == 0) sbit = tx;
                else if (b <= 8) rx[b-1] = tx;
                else begin
                    pbit = tx;
                    if (f < int'(NBYTES)) exp_b = num[f*8 +: 8];
                    else begin
                        exp_b = '0;
                        for (int k = 0; k < int'(NBYTES); k++) exp_b = exp_b ^ num[k*8 +: 8];
                    end
                    check($sformatf("%s byte%0d", name, f), 64'(rx), 64'(exp_b));
                    check($sformatf("%s start%0d", name, f), 64'(sbit), 64'(0));
                    check($sformatf("%s stop%0d", name, f), 64'(pbit), 64'(1));
                    check($sformatf("%s idx%0d", name, f), 64'(byte_idx), 64'(f));
                end
            end
            start = (c == chg_at);
            if (c == chg_at) number = chg_num;
            tick();
        end
        check({name, " busy_cycles_bad"}, 64'(bad_busy), 64'(0));
        check({name, " done_early"}, 64'(bad_done), 64'(0));
        check({name, " done_pulse"}, 64'(done), 64'(1));
        check({name, " busy_end"}, 64'(busy), 64'(0));
        check({name, " tx_end"}, 64'(tx), 64'(1));
        check({name, " idx_end"}, 64'(byte_idx), 64'(NFR - 1));
    endtask

    task automatic check_after(input string name);
        tick();
        check({name, " done_once"}, 64'(done), 64'(0));
        check({name, " idle_busy"}, 64'(busy), 64'(0));
        check({name, " idx_hold"}, 64'(byte_idx), 64'(NFR - 1));
    endtask

    initial begin
        logic [SIZE-1:0] v;
        reset  = 1'b1;
        start  = 1'b0;
        number = '0;
        tick();
        tick();
        tick();
        check("reset_state", 64'({tx, busy, done, byte_idx}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
        reset = 1'b0;

        // Idle line after reset
        for (int i = 0; i < 50; i++) begin
            number = pat(3, i);
            check($sformatf("idle c%0d", i), 64'({tx, busy, done, byte_idx}),
                  64'({1'b1, 1'b0, 1'b0, 6'd0}));
            tick();
        end

        xfer("inc", pat(1, 1), -1, '0);
        check_after("inc");

        xfer("snap", pat(5, 17), 100, pat(11, 200));
        check_after("snap");

        // Asynchronous reset mid-frame (byte 1, data bit 3)
        number = pat(1, 1);
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (57) tick();
        check("pre_reset_idx", 64'(byte_idx), 64'(1));
        check("pre_reset_tx", 64'(tx), 64'(0));
        #1 reset = 1'b1;
        #1;
        check("async_reset", 64'({tx, busy, done, byte_idx}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", 64'({tx, busy, done}), 64'({1'b1, 1'b0, 1'b0}));
        xfer("fresh", pat(7, 3), -1, '0);
        check_after("fresh");

        // Back-to-back: second start coincides with first done
        xfer("chain1", pat(13, 9), -1, '0);
        xfer("chain2", pat(255, 128), -1, '0);
        check_after("chain2");

        xfer("a5", pat(0, 165), -1, '0);
        check_after("a5");
        v = pat(0, 165);
        v[7:0] = 8'h5A;
        xfer("a5_5a", v, -1, '0);
        check_after("a5_5a");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
